// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks with the 0x80 marker and 64-bit bit length.
// Optional block counter output blk_count is enabled by defining SHA256_PAD_BLOCK_CNT_EN.
module sha256_block_padder #(
    parameter int LEN_W = 61
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
`ifdef SHA256_PAD_BLOCK_CNT_EN
    output logic [31:0]  blk_count,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_LEN  = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [511:0]       r_buf;
    logic [5:0]         r_ptr;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_pad_pending;
    logic               r_len_pending;
    logic               r_blk_last;

    logic               w_in_fire;
    logic               w_byte_fire;
    logic               w_blk_fire;
    logic               w_ptr_full;
    logic               w_len_fits;
    logic [8:0]         w_wr_lo;
    logic [63:0]        w_bit_len;
    logic [511:0]       w_pad_block;

    assign w_in_fire   = in_valid && in_ready;
    assign w_byte_fire = w_in_fire && !in_empty;
    assign w_blk_fire  = blk_valid && blk_ready;
    assign w_ptr_full  = (r_ptr == 6'd63);
    assign w_len_fits  = (r_ptr <= 6'd55);
    assign w_wr_lo     = 9'd504 - {r_ptr, 3'b000};
    assign w_bit_len   = 64'({r_cnt, 3'b000});

    // Marker at ptr, zeros after it, and the length in the tail when it still fits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_pad_block = r_buf;
        for (int i = 0; i < 64; i++) begin
            if (i == int'(r_ptr)) begin
                w_pad_block[504 - 8*i +: 8] = 8'h80;
            end else if (i > int'(r_ptr)) begin
                w_pad_block[504 - 8*i +: 8] = 8'h00;
            end
        end
        if (w_len_fits) begin
            w_pad_block[63:0] = w_bit_len;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_FILL: begin
                if (w_in_fire) begin
                    if (!in_empty && w_ptr_full) begin
                        w_next_state = S_SEND;
                    end else if (in_last) begin
                        w_next_state = S_PAD;
                    end
                end
            end
            S_PAD:  w_next_state = S_SEND;
            S_LEN:  w_next_state = S_SEND;
            S_SEND: begin
                if (w_blk_fire) begin
                    if (r_pad_pending) begin
                        w_next_state = S_PAD;
                    end else if (r_len_pending) begin
                        w_next_state = S_LEN;
                    end else begin
                        w_next_state = S_FILL;
                    end
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_FILL);
        blk_valid = (r_state == S_SEND);
        busy      = (r_state != S_FILL) || (r_ptr != 6'd0);
    end

    assign blk_data = r_buf;
    assign blk_last = r_blk_last;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the block buffer is reset because blk_data must read zero and partial messages must be dropped.
            r_buf         <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_pad_pending <= 1'b0;
            r_len_pending <= 1'b0;
            r_blk_last    <= 1'b0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (w_byte_fire) begin
                        r_buf[w_wr_lo +: 8] <= in_data;
                        r_ptr               <= r_ptr + 6'd1;
                        r_cnt               <= r_cnt + LEN_W'(1);
                        if (in_last && w_ptr_full) begin
                            r_pad_pending <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    r_buf         <= w_pad_block;
                    r_blk_last    <= w_len_fits;
                    r_len_pending <= !w_len_fits;
                end
                S_LEN: begin
                    r_buf      <= {448'd0, w_bit_len};
                    r_blk_last <= 1'b1;
                end
                S_SEND: begin
                    if (w_blk_fire) begin
                        r_buf      <= '0;
                        r_ptr      <= '0;
                        r_blk_last <= 1'b0;
                        if (r_pad_pending) begin
                            r_pad_pending <= 1'b0;
                        end else if (r_len_pending) begin
                            r_len_pending <= 1'b0;
                        end
                        // Length counter belongs to one message; restart it after the final block.
                        if (r_blk_last) begin
                            r_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_PAD_BLOCK_CNT_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blk_count <= '0;
        end else if (w_blk_fire) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_sha256_block_padder.sv
// Self-checking bench for sha256_block_padder: a reference padding model fills a scoreboard,
// and a monitor compares every accepted block against it.
module tb_sha256_block_padder;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         in_empty = 1'b0;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         busy;
`ifdef SHA256_PAD_BLOCK_CNT_EN
    logic [31:0]  blk_count;
`endif

    int errors = 0;
    int checks = 0;
    int hs_count = 0;

    logic [512:0] sb_q[$];

    bit   rand_mode = 1'b0;
    logic rnd_bit = 1'b0;
    logic ready_ctl = 1'b1;
    assign blk_ready = rand_mode ? rnd_bit : ready_ctl;

    sha256_block_padder #(.LEN_W(61)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
`ifdef SHA256_PAD_BLOCK_CNT_EN
        .blk_count (blk_count),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Handshake happens on the next rising edge when valid and ready are both high at the falling edge.
    always @(negedge clock) begin
        logic [512:0] exp_blk;
        if (reset_n && blk_valid && blk_ready) begin
            hs_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block: got last=%0b data=%h, required no block", blk_last, blk_data);
            end else begin
                exp_blk = sb_q.pop_front();
                if ({blk_last, blk_data} !== exp_blk) begin
                    errors++;
                    $display("FAIL block: got last=%0b data=%h", blk_last, blk_data);
                    $display("FAIL block: required last=%0b data=%h", exp_blk[512], exp_blk[511:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    // Reference SHA-256 padding: data, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic push_expected(input logic [7:0] msg[$]);
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        int           nblk;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            for (int j = 0; j < 64; j++) blk[504 - 8*j +: 8] = p[64*b + j];
            sb_q.push_back({(b == nblk - 1), blk});
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_empty = empty;
        for (int t = 0; t < 500; t++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got in_ready=0 for 500 cycles, required 1");
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        push_expected(msg);
        if (msg.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1);
        end else begin
            for (int i = 0; i < msg.size(); i++) send_beat(msg[i], (i == msg.size() - 1), 1'b0);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            if (sb_q.size() == 0) break;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d blocks outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (blk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got blk_valid=%0b busy=%0b, required 0 0", name, blk_valid, busy);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        #1;
        reset_n  = 1'b0;
        hs_count = 0;
        sb_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1 || blk_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0b ready=%0b last=%0b busy=%0b, required 0 1 0 0",
                     blk_valid, in_ready, blk_last, busy);
        end
        checks++;
        if (blk_data !== 512'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 0", blk_data);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_abc();
        logic [7:0] m[$];
        m = {8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_beat(8'h61, 1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abc_busy: got busy=%0b in_ready=%0b, required 1 1", busy, in_ready);
        end
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abc_pad_cycle: got valid=%0b in_ready=%0b, required 0 0", blk_valid, in_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL abc_latency: got blk_valid=%0b two cycles after last, required 1", blk_valid);
        end
        wait_drain("abc");
    endtask

    task automatic test_empty_msg();
        logic [7:0] m[$];
        m.delete();
        send_msg(m);
        wait_drain("empty_msg");
    endtask

    task automatic test_empty_discard();
        logic [7:0] m[$];
        m = {8'h61, 8'h62, 8'h63};
        push_expected(m);
        send_beat(8'h61, 1'b0, 1'b0);
        send_beat(8'hFF, 1'b0, 1'b1);
        send_beat(8'h62, 1'b0, 1'b0);
        send_beat(8'h63, 1'b1, 1'b0);
        wait_drain("empty_discard");
    endtask

    task automatic test_len_boundaries();
        logic [7:0] m[$];
        m.delete();
        for (int i = 0; i < 55; i++) m.push_back(8'h00);
        send_msg(m);
        wait_drain("len55");
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
        send_msg(m);
        wait_drain("len56");
        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom_range(0, 255)));
        push_expected(m);
        for (int i = 0; i < 64; i++) send_beat(m[i], (i == 63), 1'b0);
        checks++;
        if (blk_valid !== 1'b1) begin
            errors++;
            $display("FAIL len64_latency: got blk_valid=%0b one cycle after 64th byte, required 1", blk_valid);
        end
        wait_drain("len64");
    endtask

    task automatic test_back_to_back();
        int lens[7] = '{0, 1, 63, 100, 119, 120, 200};
        logic [7:0] m[$];
        rand_mode = 1'b1;
        foreach (lens[k]) begin
            m.delete();
            for (int i = 0; i < lens[k]; i++) m.push_back(8'($urandom_range(0, 255)));
            send_msg(m);
        end
        wait_drain("back_to_back");
        rand_mode = 1'b0;
    endtask

    task automatic test_stall_reset();
        logic [7:0] m[$];
        bit seen;
        ready_ctl = 1'b0;
        m = {8'h61, 8'h62, 8'h63};
        send_msg(m);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (blk_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_valid_timeout: got blk_valid=0, required 1");
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (sb_q.size() == 0 || {blk_last, blk_data} !== sb_q[0] || in_ready !== 1'b0 || blk_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got valid=%0b in_ready=%0b last=%0b, required 1 0 1 with stable data",
                         c, blk_valid, in_ready, blk_last);
            end
            @(negedge clock);
        end
        #2;
        reset_n  = 1'b0;
        hs_count = 0;
        sb_q.delete();
        #1;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || blk_data !== 512'd0) begin
            errors++;
            $display("FAIL stall_async_reset: got valid=%0b in_ready=%0b busy=%0b data_nonzero=%0b, required 0 1 0 0",
                     blk_valid, in_ready, busy, (blk_data != 512'd0));
        end
        @(negedge clock);
        reset_n   = 1'b1;
        ready_ctl = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got valid=%0b in_ready=%0b, required 0 1", blk_valid, in_ready);
        end
        for (int i = 0; i < 10; i++) send_beat(8'hA5, 1'b0, 1'b0);
        pulse_reset();
        m = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_msg(m);
        wait_drain("post_reset_msg");
    endtask

`ifdef SHA256_PAD_BLOCK_CNT_EN
    task automatic test_blk_count();
        logic [7:0] m[$];
        m.delete();
        for (int i = 0; i < 70; i++) m.push_back(8'(i));
        send_msg(m);
        wait_drain("blk_count_msg");
        checks++;
        if (blk_count !== 32'(hs_count)) begin
            errors++;
            $display("FAIL blk_count: got %0d, required %0d", blk_count, hs_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc();
        test_empty_msg();
        test_empty_discard();
        test_len_boundaries();
        test_back_to_back();
        test_stall_reset();
`ifdef SHA256_PAD_BLOCK_CNT_EN
        test_blk_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
